hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS core. It generates the F/D stall controls and the E-stage bubble clear (`clr`) for the ID/EX register. It also times the shared multiply/divide unit's busy window and runs the hardware-interrupt entry/return sequence, which drives the pipeline-wide `HWInt` flush, the PC redirect select and the EPC register. Purely a controller: it holds no datapath operands beyond EPC.

---
 rtl/hazard_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline sequencing controller for the five-stage MIPS core.
//   - Detects load-use, branch-operand and mult/div hazards and turns them
//     into F/D stalls plus an ID/EX bubble.
//   - Times the shared mult/div unit's busy window with a saturating down
//     counter.
//   - Sequences hardware-interrupt entry and eret return. It drives the
//     pipeline flush (hwint), the PC redirect select, EPC and the EXL flag.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   rs_d, rt_d, use_rs_d/rt_d    D-stage sources and whether they are read
//   branch_d                     D instruction resolves a branch/jr in D
//   a3_e/m, regwrite_e/m         E/M destination register and write enable
//   memtoreg_e/m                 2'b01 marks a load
//   md_start_e, md_isdiv_e       mult/div issuing in E, and whether it divides
//   md_use_d                     D instruction touches the mult/div unit
//   eret_d                       D instruction is eret
//   int_req, ie                  masked interrupt request, global enable
//   pc_d                         PC of the D-stage instruction
//   stall_f, stall_d, clr_e      hold PC / IF-ID, bubble into ID/EX
//   hwint                        flush IF/ID, ID/EX, EX/MEM
//   pc_sel                       00 normal, 10 handler, 11 EPC
//   epc, exl, md_busy            saved return PC, in-handler flag, MD busy
module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic        use_rs_d,
  input  logic        use_rt_d,
  input  logic        branch_d,
  input  logic [4:0]  a3_e,
  input  logic [4:0]  a3_m,
  input  logic        regwrite_e,
  input  logic        regwrite_m,
  input  logic [1:0]  memtoreg_e,
  input  logic [1:0]  memtoreg_m,
  input  logic        md_start_e,
  input  logic        md_isdiv_e,
  input  logic        md_use_d,
  input  logic        eret_d,
  input  logic        int_req,
  input  logic        ie,
  input  logic [31:0] pc_d,
  output logic        stall_f,
  output logic        stall_d,
  output logic        clr_e,
  output logic        hwint,
  output logic [1:0]  pc_sel,
  output logic [31:0] epc,
  output logic        exl,
  output logic        md_busy
);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT_MD,
    S_ENTER,
    S_HANDLER
  } state_t;

  localparam logic [1:0] PC_NORMAL  = 2'b00;
  localparam logic [1:0] PC_HANDLER = 2'b10;
  localparam logic [1:0] PC_EPC     = 2'b11;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic        exl_q, exl_d;

  logic hit_e, hit_m;
  logic load_e, load_m;
  logic stall_lu, stall_br, stall_md, stall_any;
  logic eret_go;

  // ---------------------------------------------------------------------------
  // Hazard detection. $0 is never a real dependency.
  // ---------------------------------------------------------------------------
  always_comb begin
    hit_e  = (a3_e != 5'd0) &&
             ((use_rs_d && (a3_e == rs_d)) || (use_rt_d && (a3_e == rt_d)));
    hit_m  = (a3_m != 5'd0) &&
             ((use_rs_d && (a3_m == rs_d)) || (use_rt_d && (a3_m == rt_d)));
    load_e = (memtoreg_e == 2'b01) && regwrite_e;
    load_m = (memtoreg_m == 2'b01) && regwrite_m;

    stall_lu  = load_e && hit_e;
    // A branch resolving in D cannot use any E result (not even ALU, which
    // is only forwardable from M) nor a load still sitting in M.
    stall_br  = branch_d && ((regwrite_e && hit_e) || (load_m && hit_m));
    // A start in E this cycle makes the unit busy from the next cycle on.
    stall_md  = md_use_d && (md_busy || md_start_e);
    stall_any = stall_lu || stall_br || stall_md;
  end

  assign md_busy = (cnt_q != 4'd0);
  assign epc     = epc_q;
  assign exl     = exl_q;

  // ---------------------------------------------------------------------------
  // Mult/div busy counter: load on start, count down, saturate at zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (md_start_e) begin
      cnt_d = md_isdiv_e ? 4'(DIV_CYC) : 4'(MULT_CYC);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt sequencer: next state and outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    exl_d   = exl_q;
    hwint   = 1'b0;
    pc_sel  = PC_NORMAL;
    eret_go = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (int_req && ie && !exl_q) begin
          // Entry must wait for the MD unit so its result is not lost.
          state_d = md_busy ? S_WAIT_MD : S_ENTER;
        end
      end
      S_WAIT_MD: begin
        // Committed: a dropped int_req does not cancel the entry.
        if (!md_busy) begin
          state_d = S_ENTER;
        end
      end
      S_ENTER: begin
        hwint   = 1'b1;
        pc_sel  = PC_HANDLER;
        epc_d   = pc_d;
        exl_d   = 1'b1;
        state_d = S_HANDLER;
      end
      S_HANDLER: begin
        // eret only takes effect once its own operands are hazard-free.
        eret_go = eret_d && !stall_any;
        if (eret_go) begin
          hwint   = 1'b1;
          pc_sel  = PC_EPC;
          exl_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase

    // A flush supersedes any stall: the stalled instruction is discarded.
    stall_f = stall_any && !hwint;
    stall_d = stall_any && !hwint;
    clr_e   = stall_any && !hwint;
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RUN;
      cnt_q   <= 4'd0;
      epc_q   <= 32'd0;
      exl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      exl_q   <= exl_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset_n;
  logic [4:0]  rs_d, rt_d, a3_e, a3_m;
  logic        use_rs_d, use_rt_d, branch_d;
  logic        regwrite_e, regwrite_m;
  logic [1:0]  memtoreg_e, memtoreg_m;
  logic        md_start_e, md_isdiv_e, md_use_d, eret_d, int_req, ie;
  logic [31:0] pc_d;
  logic        stall_f, stall_d, clr_e, hwint, exl, md_busy;
  logic [1:0]  pc_sel;
  logic [31:0] epc;

  int tests;
  int fails;

  // Behavioural model: cycles of MD work left, entry pending/now, handler flag.
  int          m_busy_left;
  bit          m_pending;
  bit          m_entering;
  bit          m_exl;
  logic [31:0] m_epc;

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .branch_d(branch_d), .a3_e(a3_e), .a3_m(a3_m),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
    .md_start_e(md_start_e), .md_isdiv_e(md_isdiv_e), .md_use_d(md_use_d),
    .eret_d(eret_d), .int_req(int_req), .ie(ie), .pc_d(pc_d),
    .stall_f(stall_f), .stall_d(stall_d), .clr_e(clr_e), .hwint(hwint),
    .pc_sel(pc_sel), .epc(epc), .exl(exl), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return (r != 5'd0) && ((use_rs_d && r == rs_d) || (use_rt_d && r == rt_d));
  endfunction

  task automatic model_clear();
    m_busy_left = 0;
    m_pending   = 1'b0;
    m_entering  = 1'b0;
    m_exl       = 1'b0;
    m_epc       = 32'd0;
  endtask

  task automatic idle_inputs();
    rs_d = 0; rt_d = 0; a3_e = 0; a3_m = 0;
    use_rs_d = 0; use_rt_d = 0; branch_d = 0;
    regwrite_e = 0; regwrite_m = 0; memtoreg_e = 0; memtoreg_m = 0;
    md_start_e = 0; md_isdiv_e = 0; md_use_d = 0; eret_d = 0;
    int_req = 0; ie = 0; pc_d = 32'h0000_3000;
  endtask

  // One clock cycle: compare DUT with the model at the falling edge, then
  // advance the model across the rising edge. Returns at posedge + 1.
  task automatic tick();
    bit st, ret, hw, exp_stall;
    int ps;
    int n_busy;
    bit n_pending, n_entering, n_exl;
    logic [31:0] n_epc;

    @(negedge clk);
    st = (memtoreg_e == 2'b01 && regwrite_e && reads(a3_e))
       || (branch_d && ((regwrite_e && reads(a3_e)) ||
                        (memtoreg_m == 2'b01 && regwrite_m && reads(a3_m))))
       || (md_use_d && (m_busy_left > 0 || md_start_e));
    ret = m_exl && eret_d && !st;
    hw  = m_entering || ret;
    ps  = m_entering ? 2 : (ret ? 3 : 0);
    exp_stall = st && !hw;

    chk("stall_f", 32'(stall_f), 32'(exp_stall));
    chk("stall_d", 32'(stall_d), 32'(exp_stall));
    chk("clr_e",   32'(clr_e),   32'(exp_stall));
    chk("hwint",   32'(hwint),   32'(hw));
    chk("pc_sel",  32'(pc_sel),  32'(ps));
    chk("md_busy", 32'(md_busy), 32'(m_busy_left > 0));
    chk("epc",     epc,          m_epc);
    chk("exl",     32'(exl),     32'(m_exl));

    n_busy = md_start_e ? (md_isdiv_e ? 10 : 5) : (m_busy_left > 0 ? m_busy_left - 1 : 0);
    n_pending = m_pending; n_entering = 1'b0; n_exl = m_exl; n_epc = m_epc;
    if (m_entering) begin
      n_exl = 1'b1;
      n_epc = pc_d;
    end else if (ret) begin
      n_exl = 1'b0;
    end else if (m_pending) begin
      if (m_busy_left == 0) begin
        n_pending  = 1'b0;
        n_entering = 1'b1;
      end
    end else if (!m_exl && int_req && ie) begin
      if (m_busy_left > 0) n_pending = 1'b1;
      else                 n_entering = 1'b1;
    end

    @(posedge clk);
    if (!reset_n) begin
      model_clear();
    end else begin
      m_busy_left = n_busy;
      m_pending   = n_pending;
      m_entering  = n_entering;
      m_exl       = n_exl;
      m_epc       = n_epc;
    end
    #1;
  endtask

  task automatic random_inputs();
    rs_d = 5'($urandom_range(0, 3));
    rt_d = 5'($urandom_range(0, 3));
    a3_e = 5'($urandom_range(0, 3));
    a3_m = 5'($urandom_range(0, 3));
    use_rs_d   = 1'($urandom_range(0, 1));
    use_rt_d   = 1'($urandom_range(0, 1));
    branch_d   = ($urandom_range(0, 3) == 0);
    regwrite_e = 1'($urandom_range(0, 1));
    regwrite_m = 1'($urandom_range(0, 1));
    memtoreg_e = 2'($urandom_range(0, 2));
    memtoreg_m = 2'($urandom_range(0, 2));
    md_start_e = ($urandom_range(0, 7) == 0);
    md_isdiv_e = 1'($urandom_range(0, 1));
    md_use_d   = ($urandom_range(0, 3) == 0);
    eret_d     = ($urandom_range(0, 4) == 0);
    int_req    = ($urandom_range(0, 9) == 0);
    ie         = ($urandom_range(0, 3) != 0);
    pc_d       = $urandom & 32'hFFFF_FFFC;
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;

    // ---------------- reset ----------------
    reset_n = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hwint",   32'(hwint),   32'd0);
    chk("rst_pc_sel",  32'(pc_sel),  32'd0);
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    chk("rst_exl",     32'(exl),     32'd0);
    chk("rst_epc",     epc,          32'd0);
    chk("rst_stall",   32'(stall_f), 32'd0);
    // Stall logic is combinational and still answers during reset.
    memtoreg_e = 2'b01; regwrite_e = 1; a3_e = 5'd8; rs_d = 5'd8; use_rs_d = 1;
    #1;
    chk("rst_stall_follows", 32'(stall_f), 32'd1);
    idle_inputs();
    reset_n = 1'b1;
    tick();

    // ---------------- load-use ----------------
    memtoreg_e = 2'b01; regwrite_e = 1; a3_e = 5'd8; rs_d = 5'd8; use_rs_d = 1;
    #1;
    chk("lu_stall", 32'(stall_f), 32'd1);
    chk("lu_clr",   32'(clr_e),   32'd1);
    tick();
    memtoreg_e = 2'b00; regwrite_e = 0; a3_e = 5'd0;   // bubble now in E
    #1;
    chk("lu_release", 32'(stall_f), 32'd0);
    tick();
    memtoreg_e = 2'b01; regwrite_e = 1; a3_e = 5'd0; rs_d = 5'd0;
    #1;
    chk("lu_r0", 32'(stall_f), 32'd0);
    tick();
    idle_inputs();

    // ---------------- branch: ALU in E, then load in M ----------------
    branch_d = 1; rs_d = 5'd9; use_rs_d = 1;
    regwrite_e = 1; a3_e = 5'd9;
    #1;
    chk("br_alu_e", 32'(stall_d), 32'd1);
    tick();
    regwrite_e = 0; a3_e = 0;
    regwrite_m = 1; a3_m = 5'd9; memtoreg_m = 2'b01;
    #1;
    chk("br_load_m", 32'(stall_d), 32'd1);
    tick();
    idle_inputs();
    tick();

    // ---------------- divide then mflo ----------------
    md_start_e = 1; md_isdiv_e = 1; md_use_d = 1;
    #1;
    chk("div_issue_stall", 32'(stall_f), 32'd1);
    tick();
    md_start_e = 0; md_isdiv_e = 0;
    n = 0;
    while (md_busy && n < 20) begin
      chk("div_busy_stall", 32'(stall_f), 32'd1);
      n++;
      tick();
    end
    chk("div_busy_cycles", 32'(n), 32'd10);
    chk("div_release", 32'(stall_f), 32'd0);
    idle_inputs();
    tick();

    // ---------------- interrupt while idle ----------------
    int_req = 1; ie = 1; pc_d = 32'h0000_3010;
    #1;
    chk("int_n_hwint", 32'(hwint), 32'd0);
    tick();
    int_req = 0;
    #1;
    chk("int_enter_hwint",  32'(hwint),  32'd1);
    chk("int_enter_pc_sel", 32'(pc_sel), 32'd2);
    tick();
    chk("int_epc", epc, 32'h0000_3010);
    chk("int_exl", 32'(exl), 32'd1);
    int_req = 1; pc_d = 32'h0000_4180;
    tick();
    int_req = 0;
    #1;
    chk("int_nested_ignored", 32'(hwint), 32'd0);
    eret_d = 1;
    #1;
    chk("eret_pc_sel", 32'(pc_sel), 32'd3);
    chk("eret_hwint",  32'(hwint),  32'd1);
    tick();
    eret_d = 0;
    #1;
    chk("eret_exl", 32'(exl), 32'd0);
    tick();

    // ---------------- interrupt during multiply ----------------
    md_start_e = 1; md_isdiv_e = 0;
    tick();
    md_start_e = 0;
    tick();
    int_req = 1; ie = 1; pc_d = 32'h0000_3020;
    tick();
    int_req = 0;   // dropping the request does not cancel the entry
    n = 0;
    while (!hwint && n < 20) begin
      tick();
      n++;
    end
    chk("mult_int_delay", 32'(n), 32'd4);
    chk("mult_int_busy",  32'(md_busy), 32'd0);
    chk("mult_int_pc_sel", 32'(pc_sel), 32'd2);
    tick();
    eret_d = 1;
    #1;
    chk("mult_eret_pc_sel", 32'(pc_sel), 32'd3);
    tick();
    eret_d = 0;
    #1;
    chk("mult_eret_exl", 32'(exl), 32'd0);
    chk("mult_eret_hw",  32'(hwint), 32'd0);
    tick();

    // ---------------- async reset mid-divide ----------------
    md_start_e = 1; md_isdiv_e = 1;
    tick();
    md_start_e = 0;
    repeat (4) tick();   // counter now at 6
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("rst_div_busy", 32'(md_busy), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // ---------------- async reset mid-ENTER ----------------
    int_req = 1; ie = 1; pc_d = 32'h0000_3030;
    tick();
    int_req = 0;
    #1;
    chk("rst_enter_pre", 32'(hwint), 32'd1);
    #1;
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("rst_enter_hwint",  32'(hwint),  32'd0);
    chk("rst_enter_pc_sel", 32'(pc_sel), 32'd0);
    chk("rst_enter_exl",    32'(exl),    32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_enter_after_exl", 32'(exl), 32'd0);

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
